// File: rtl/vga_sync_generator_pkg.sv
// Shared definitions for the VGA sync generator: axis region encoding and the
// default 640x480 @ 60 Hz timing constants.
package vga_sync_generator_pkg;

  // Horizontal and vertical scans walk the same four regions in the same order.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_t;

  localparam int DEF_COUNT_SIZE = 10;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC_LEN = 96;
  localparam int DEF_H_BACK     = 48;

  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC_LEN = 2;
  localparam int DEF_V_BACK     = 33;

endpackage

// File: rtl/vga_sync_generator_sync_axis_counter.sv
// One scan axis: a wrapping position counter plus the active/front/sync/back
// region FSM. Every region length must be at least 1.
module sync_axis_counter
  import vga_sync_generator_pkg::*;
#(
  parameter int CountSize = DEF_COUNT_SIZE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 enable,
  input  logic [CountSize-1:0] visible_len,
  input  logic [CountSize-1:0] front_len,
  input  logic [CountSize-1:0] sync_len,
  input  logic [CountSize-1:0] back_len,
  output logic [CountSize-1:0] count,
  output axis_state_t          state,
  output axis_state_t          state_next,
  output logic                 wrap
);

  localparam logic [CountSize-1:0] ONE = CountSize'(1);

  logic [CountSize-1:0] last_active;
  logic [CountSize-1:0] last_front;
  logic [CountSize-1:0] last_sync;
  logic [CountSize-1:0] last_back;
  logic [CountSize-1:0] count_next;

  always_comb begin
    last_active = visible_len - ONE;
    last_front  = last_active + front_len;
    last_sync   = last_front + sync_len;
    last_back   = last_sync + back_len;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
      state <= ST_ACTIVE;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

  // A region is left on the enable where the counter sits on its last count.
  always_comb begin
    count_next = count;
    state_next = state;
    if (enable) begin
      count_next = wrap ? '0 : count + ONE;
      case (state)
        ST_ACTIVE: if (count == last_active) state_next = ST_FRONT;
        ST_FRONT:  if (count == last_front)  state_next = ST_SYNC;
        ST_SYNC:   if (count == last_sync)   state_next = ST_BACK;
        ST_BACK:   if (count == last_back)   state_next = ST_ACTIVE;
        default:   state_next = ST_ACTIVE;
      endcase
    end
  end

  always_comb begin
    wrap = (count == last_back);
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync/timing generator driven by the PixelClock square wave.
// Optional FrameCount output enabled with `define VGA_FRAME_COUNT_EN.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int CountSize = DEF_COUNT_SIZE,
  parameter int HVisible  = DEF_H_VISIBLE,
  parameter int HFront    = DEF_H_FRONT,
  parameter int HSyncLen  = DEF_H_SYNC_LEN,
  parameter int HBack     = DEF_H_BACK,
  parameter int VVisible  = DEF_V_VISIBLE,
  parameter int VFront    = DEF_V_FRONT,
  parameter int VSyncLen  = DEF_V_SYNC_LEN,
  parameter int VBack     = DEF_V_BACK
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 PixelClock,
  output logic                 HSync,
  output logic                 VSync,
  output logic                 DisplayEnable,
  output logic [CountSize-1:0] PixelX,
  output logic [CountSize-1:0] PixelY,
  output logic                 LineStart,
  output logic                 FrameStart
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]           FrameCount
`endif
);

  localparam logic [CountSize-1:0] H_VIS_LEN   = CountSize'(HVisible);
  localparam logic [CountSize-1:0] H_FRONT_LEN = CountSize'(HFront);
  localparam logic [CountSize-1:0] H_SYNC_LEN  = CountSize'(HSyncLen);
  localparam logic [CountSize-1:0] H_BACK_LEN  = CountSize'(HBack);
  localparam logic [CountSize-1:0] V_VIS_LEN   = CountSize'(VVisible);
  localparam logic [CountSize-1:0] V_FRONT_LEN = CountSize'(VFront);
  localparam logic [CountSize-1:0] V_SYNC_LEN  = CountSize'(VSyncLen);
  localparam logic [CountSize-1:0] V_BACK_LEN  = CountSize'(VBack);

  logic        pixel_clock_q;
  logic        tick;
  logic        h_wrap;
  logic        v_wrap;
  logic        line_wrap;
  logic        frame_wrap;
  axis_state_t h_state;
  axis_state_t h_state_next;
  axis_state_t v_state;
  axis_state_t v_state_next;

  assign tick       = PixelClock & ~pixel_clock_q;
  assign line_wrap  = tick & h_wrap;
  assign frame_wrap = line_wrap & v_wrap;

  sync_axis_counter #(.CountSize(CountSize)) u_h_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .enable      (tick),
    .visible_len (H_VIS_LEN),
    .front_len   (H_FRONT_LEN),
    .sync_len    (H_SYNC_LEN),
    .back_len    (H_BACK_LEN),
    .count       (PixelX),
    .state       (h_state),
    .state_next  (h_state_next),
    .wrap        (h_wrap)
  );

  sync_axis_counter #(.CountSize(CountSize)) u_v_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .enable      (line_wrap),
    .visible_len (V_VIS_LEN),
    .front_len   (V_FRONT_LEN),
    .sync_len    (V_SYNC_LEN),
    .back_len    (V_BACK_LEN),
    .count       (PixelY),
    .state       (v_state),
    .state_next  (v_state_next),
    .wrap        (v_wrap)
  );

  // pixel_clock_q resets high so a PixelClock held high at release is not a rise.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pixel_clock_q <= 1'b1;
      HSync         <= 1'b1;
      VSync         <= 1'b1;
      DisplayEnable <= 1'b1;
      LineStart     <= 1'b0;
      FrameStart    <= 1'b0;
    end else begin
      pixel_clock_q <= PixelClock;
      LineStart     <= line_wrap;
      FrameStart    <= frame_wrap;
      if (tick) begin
        HSync         <= (h_state_next != ST_SYNC);
        VSync         <= (v_state_next != ST_SYNC);
        DisplayEnable <= (h_state_next == ST_ACTIVE) && (v_state_next == ST_ACTIVE);
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      FrameCount <= 8'd0;
    end else if (frame_wrap) begin
      FrameCount <= FrameCount + 8'd1;
    end
  end
`endif

  // The registered sync/enable outputs always agree with the region FSMs.
  a_outputs_track_state: assert property (@(posedge Clock) disable iff (!Reset)
    (HSync == (h_state != ST_SYNC)) && (VSync == (v_state != ST_SYNC)) &&
    (DisplayEnable == ((h_state == ST_ACTIVE) && (v_state == ST_ACTIVE))));

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Consumes the PixelClock square wave from the pixel-clock divider and produces VGA HSync/VSync, a display-enable strobe and the current pixel coordinates for the Pong renderer. It re-samples PixelClock in the system Clock domain and advances its horizontal/vertical counters once per PixelClock rising edge. Default timing is 640x480 at 60 Hz. It sits between the divider and the Pong pixel/colour logic.

## Interface
- CountSize, 10: width of horizontal/vertical counters and coordinate outputs
- HVisible, 640; HFront, 16; HSyncLen, 96; HBack, 48: horizontal region lengths in pixels
- VVisible, 480; VFront, 10; VSyncLen, 2; VBack, 33: vertical region lengths in lines
- Clock  input  1  system clock; all state changes on posedge
- Reset  input  1  asynchronous, active-low reset
- PixelClock  input  1  square wave from divider, synchronous to Clock
- HSync  output  1  horizontal sync, active low
- VSync  output  1  vertical sync, active low
- DisplayEnable  output  1  high while (PixelX, PixelY) is inside the visible area
- PixelX  output  CountSize  current horizontal count, 0..HTotal-1
- PixelY  output  CountSize  current vertical count, 0..VTotal-1
- LineStart  output  1  one-Clock pulse when PixelX wraps to 0
- FrameStart  output  1  one-Clock pulse when (PixelX, PixelY) wraps to (0, 0)

## Operation
- HTotal = HVisible+HFront+HSyncLen+HBack (800); VTotal = VVisible+VFront+VSyncLen+VBack (525).
- PixelClockQ registers PixelClock every Clock cycle. Tick = PixelClock & ~PixelClockQ.
- Horizontal FSM: H_ACTIVE (0..HVisible-1) -> H_FRONT -> H_SYNC -> H_BACK -> H_ACTIVE. Transitions happen on Tick when the counter reaches the region's last count.
- Vertical FSM: V_ACTIVE -> V_FRONT -> V_SYNC -> V_BACK -> V_ACTIVE. It advances only on a Tick where PixelX = HTotal-1.
- On Tick: PixelX increments, wrapping HTotal-1 -> 0. On that wrap, PixelY increments, wrapping VTotal-1 -> 0.
- HSync = 0 iff in H_SYNC (PixelX 656..751 by default). VSync = 0 iff in V_SYNC (PixelY 490..491).
- DisplayEnable = H_ACTIVE & V_ACTIVE.
- Without Tick, all counters, states and level outputs hold.
- LineStart and FrameStart are high only in the Clock cycle after the Tick that caused the wrap.
- Reset values: PixelX=0, PixelY=0, H_ACTIVE, V_ACTIVE, HSync=1, VSync=1, DisplayEnable=1, LineStart=0, FrameStart=0, PixelClockQ=1.
- PixelClockQ resets to 1 so that PixelClock held high at reset release produces no spurious Tick.
- Reset asserted mid-frame returns immediately to the reset state. Scanning restarts from (0, 0) at the first Tick after release.

## Timing
- All outputs are registered. They update on the Clock edge where Tick=1 and describe the new counter values (computed from next-state).
- Latency: one Clock from the PixelClock rise being sampled high (with PixelClockQ low) to the outputs changing.
- Minimum PixelClock period is 2 Clock cycles. With 50 MHz / 25 MHz input, Tick occurs every 2nd Clock.
- One frame = HTotal*VTotal = 420000 Ticks.

## Configuration
- VGA_FRAME_COUNT_EN defined: adds output FrameCount [7:0], reset 0. It increments (mod 256) in the same cycle FrameStart pulses; Pong uses it for ball-speed pacing.
- VGA_FRAME_COUNT_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package: the H/V state encodings (2-bit enums) and the default 640x480 timing constants.
- One sub-module, sync_axis_counter, instantiated twice (horizontal, vertical):
  - inputs: enable, region lengths
  - outputs: count, state, wrap
  - the vertical instance is enabled by Tick & horizontal wrap.

## Test plan
- Reset low, PixelClock toggling -> PixelX=0, PixelY=0, HSync=1, VSync=1, DisplayEnable=1 held. After release, first PixelClock rise -> PixelX=1 one Clock later.
- Free-run at Clock/2 tick rate -> HSync low exactly for PixelX 656..751 (96 Ticks). DisplayEnable drops when PixelX goes 639 -> 640.
- Run one line -> LineStart pulses exactly one Clock as PixelX wraps 799 -> 0. PixelY increments 0 -> 1 on the same edge.
- Run a full frame -> VSync low for PixelY 490..491. FrameStart pulses once after 420000 Ticks at (0, 0).
- Stop PixelClock for 10 Clocks mid-line -> all outputs hold. Assert Reset mid-frame (PixelY=300) -> immediate return to reset values.
- With VGA_FRAME_COUNT_EN, run 257 frames -> FrameCount wraps 255 -> 0 and reads 1.
